data_mem_responder: RTL

- Responder end of the ALU-to-data-memory interface.
- Accepts a memory request whose address is the ALU result and whose store data is register read data 2.
- Performs a word access into local storage with a fixed, parameterised latency.
- Returns the writeback value (loaded word or pass-through ALU result, selected by memToRegFlag), plus a one-cycle done pulse and an error flag.

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_array.sv | 38 +++
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
//   - state_e : responder FSM states
//   - op_e    : captured request kind (BAD = read and write both asserted)
//   - DATA_W_DEF : default data/address width
//   - idx_width(): word-index width for a given storage depth
package data_mem_responder_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_BAD   = 2'd3
  } op_e;

  // log2(depth), never less than 1 so index slices stay legal
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the data memory responder.
// Synchronous write, combinational read, synchronous clear on reset.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high clear of every word
//   i_we         : write enable for the addressed word
//   i_idx        : word index shared by read and write
//   i_wdata      : write data
//   o_rdata_c    : combinational read of the addressed word
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_we,
  input  logic [idx_width(DEPTH)-1:0]  i_idx,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Clear-all on reset, otherwise single-word write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the ALU-to-data-memory interface.
// Samples a load/store in IDLE, waits LATENCY cycles in ACCESS, then
// presents the writeback value with a one-cycle done pulse in RESPOND.
// Ports:
//   clock, reset         : clock and synchronous active-high reset
//   memReadFlag          : load request
//   memWriteFlag         : store request
//   memToRegFlag         : 1 = writeback loaded word, 0 = writeback address
//   address              : byte address (ALU result)
//   writeData            : store data (register read data 2)
//   readData             : registered writeback value
//   busy                 : request in flight
//   done                 : one-cycle response pulse
//   error                : qualifies done, request rejected
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memReadFlag,
  input  logic              memWriteFlag,
  input  logic              memToRegFlag,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned    IDX_W    = idx_width(DEPTH);
  localparam int unsigned    CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e            r_state;
  state_e            w_next_state;
  op_e               r_op;
  op_e               w_op;
  logic              r_m2r;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_read_data;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic              w_req;
  logic              w_last;
  logic              w_invalid;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_error_nxt;

  assign w_req  = memReadFlag | memWriteFlag;
  assign w_last = (r_state == ST_ACCESS) && (r_cnt == '0);
  assign w_idx  = r_addr[IDX_W+1:2];

  // Misaligned, any bit at or above 4*DEPTH, or both flags set
  assign w_invalid = (|r_addr[1:0]) | (|r_addr[DATA_W-1:IDX_W+2]) | (r_op == OP_BAD);

  always_comb begin
    unique case ({memReadFlag, memWriteFlag})
      2'b11:   w_op = OP_BAD;
      2'b10:   w_op = OP_LOAD;
      2'b01:   w_op = OP_STORE;
      default: w_op = OP_NONE;
    endcase
  end

  data_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_we      (w_mem_we),
    .i_idx     (w_idx),
    .i_wdata   (r_wdata),
    .o_rdata_c (w_mem_rdata)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_req)  w_next_state = ST_ACCESS;
      ST_ACCESS:  if (w_last) w_next_state = ST_RESPOND;
      ST_RESPOND: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs plus the store strobe
  always_comb begin
    w_mem_we    = 1'b0;
    w_rd_nxt    = r_read_data;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) w_busy_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (w_last) begin
          w_done_nxt = 1'b1;
          if (w_invalid) begin
            w_error_nxt = 1'b1;
            w_rd_nxt    = '0;
          end else begin
            w_error_nxt = 1'b0;
            if (r_op == OP_STORE) begin
              w_mem_we = 1'b1;
              w_rd_nxt = r_addr;
            end else begin
              w_rd_nxt = r_m2r ? w_mem_rdata : r_addr;
            end
          end
        end
      end
      ST_RESPOND: begin
        w_busy_nxt  = 1'b0;
        w_error_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Request capture, latency counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op        <= OP_NONE;
      r_m2r       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_req) begin
        r_op    <= w_op;
        r_m2r   <= memToRegFlag;
        r_addr  <= address;
        r_wdata <= writeData;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_read_data <= w_rd_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign readData = r_read_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule
